// File: rtl/prbs_pkg.sv
// PRBS9 constants and state enum shared by the prbs9 generator and checker.
package prbs_pkg;

  localparam int PRBS9_LEN = 9;
  localparam int PRBS9_TAP = 5;

  typedef enum logic [1:0] {
    FILL,
    ACQUIRE,
    LOCKED
  } prbs_state_t;

  // Next bit predicted from history (bit 0 newest): b[n] = b[n-9] ^ b[n-5].
  function automatic logic prbs9_pred(input logic [PRBS9_LEN-1:0] hist);
    return hist[PRBS9_LEN-1] ^ hist[PRBS9_TAP-1];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset/clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/prbs9_checker.sv
// Self-synchronizing PRBS9 checker: acquires lock from the line, then free-runs
// a local LFSR and counts bits, errors and loss-of-sync events.
module prbs9_checker
  import prbs_pkg::*;
#(
  parameter int NB_CNT     = 64,
  parameter int LOCK_CNT   = 16,
  parameter int WINDOW     = 64,
  parameter int ERR_THRESH = 8
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_rx,
  input  logic              i_valid,
  input  logic              i_clear,
  output logic              o_lock,
  output logic [NB_CNT-1:0] o_errors,
  output logic [NB_CNT-1:0] o_bits,
  output logic [15:0]       o_sync_loss
);

  localparam int WB = $clog2(WINDOW);

  prbs_state_t          state;
  logic [PRBS9_LEN-1:0] hist;
  logic [3:0]           fill;
  logic [7:0]           good;
  logic [WB-1:0]        win_cnt;
  logic [WB:0]          win_err;

  logic        pred;
  logic        miss;
  logic        win_end;
  logic [WB:0] win_total;
  logic        trip;
  logic        count_bit;
  logic        count_err;
  logic        count_loss;

  always_comb begin
    pred       = prbs9_pred(hist);
    miss       = i_rx ^ pred;
    win_end    = (win_cnt == WB'(WINDOW - 1));
    win_total  = win_err + (WB+1)'(miss);
    trip       = win_end && (win_total > (WB+1)'(ERR_THRESH));
    count_bit  = i_valid && (state == LOCKED);
    count_err  = count_bit && miss;
    count_loss = count_bit && trip;
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state   <= FILL;
      hist    <= '0;
      fill    <= '0;
      good    <= '0;
      win_cnt <= '0;
      win_err <= '0;
      o_lock  <= 1'b0;
    end else if (i_valid) begin
      case (state)
        FILL: begin
          hist <= {hist[PRBS9_LEN-2:0], i_rx};
          fill <= fill + 1'b1;
          if (fill == 4'(PRBS9_LEN - 1)) state <= ACQUIRE;
        end
        ACQUIRE: begin
          hist <= {hist[PRBS9_LEN-2:0], i_rx};
          if (!miss && (hist != '0)) begin
            good <= good + 1'b1;
            if (good == 8'(LOCK_CNT - 1)) begin
              state  <= LOCKED;
              o_lock <= 1'b1;
            end
          end else begin
            good <= '0;
          end
        end
        LOCKED: begin
          // Local LFSR shifts its own prediction so a line error is counted once.
          hist    <= {hist[PRBS9_LEN-2:0], pred};
          win_cnt <= win_cnt + 1'b1;
          if (win_end) begin
            win_err <= '0;
            if (trip) begin
              state  <= ACQUIRE;
              good   <= '0;
              o_lock <= 1'b0;
            end
          end else begin
            win_err <= win_total;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  sat_counter #(.WIDTH(NB_CNT)) u_errors (
    .clock(clock), .reset(i_reset), .clear(i_clear), .inc(count_err),  .count(o_errors)
  );

  sat_counter #(.WIDTH(NB_CNT)) u_bits (
    .clock(clock), .reset(i_reset), .clear(i_clear), .inc(count_bit),  .count(o_bits)
  );

  sat_counter #(.WIDTH(16)) u_sync_loss (
    .clock(clock), .reset(i_reset), .clear(i_clear), .inc(count_loss), .count(o_sync_loss)
  );

endmodule

// File: doc/prbs9_checker.md
# prbs9_checker

Self-synchronizing PRBS9 receiver that locks onto an incoming PRBS9 bit stream without a reference copy or known link delay, then counts received bits and bit errors. Sits at the far end of a link driven by `prbs9`. It replaces the aligned-reference requirement of `ber` (external delay line plus reference bit) with autonomous acquisition, loss-of-sync detection and re-acquisition.

## Interface
Parameters:
- `NB_CNT`, 64: width of `o_errors` and `o_bits`.
- `LOCK_CNT`, 16: consecutive correct predictions required to lock (1..255).
- `WINDOW`, 64: locked bits per error-monitoring window (power of 2, ≥ 8).
- `ERR_THRESH`, 8: sync is declared lost when window errors exceed this value (< `WINDOW`).

Ports:
- `clock`  in  1  system clock; all logic on its rising edge.
- `i_reset`  in  1  synchronous reset, active-high.
- `i_rx`  in  1  received bit, sampled when `i_valid`=1.
- `i_valid`  in  1  `i_rx` is valid this cycle; cycles with `i_valid`=0 change nothing except `i_clear` effects.
- `i_clear`  in  1  synchronous clear of `o_errors`, `o_bits`, `o_sync_loss`; lock state untouched.
- `o_lock`  out  1  1 while in LOCKED.
- `o_errors`  out  NB_CNT  error count since reset/clear.
- `o_bits`  out  NB_CNT  compared-bit count since reset/clear.
- `o_sync_loss`  out  16  number of LOCKED→ACQUIRE transitions.

## Operation
- Polynomial x^9+x^5+1. The self-sync relation for any seed is b[n] = b[n-9] ^ b[n-5].
- `hist[8:0]` holds the last 9 bits, `hist[0]` newest. Prediction `pred = hist[8] ^ hist[4]`.
- FSM states:
  - FILL: shift `i_rx` into `hist` on each valid bit. After 9 valid bits → ACQUIRE.
  - ACQUIRE: on each valid bit, shift in `i_rx`.
    - `good` increments if `i_rx == pred` and `hist != 0`; otherwise `good` clears.
    - When `good` reaches `LOCK_CNT` → LOCKED.
  - LOCKED: `hist` becomes a free-running local LFSR and shifts in `pred`, not `i_rx`. A single line error therefore counts as exactly one error, with no multiplication.
    - Each valid bit: `o_bits`+1; if `i_rx != pred`, `o_errors`+1 and `win_err`+1.
    - `win_cnt` counts locked valid bits modulo `WINDOW`. On the `WINDOW`-th bit, the error total for the window includes that bit.
    - If that total > `ERR_THRESH`: go to ACQUIRE, `good`=0, `o_sync_loss`+1. `hist` keeps its current contents and resumes shifting `i_rx`.
    - At every window end, `win_err` clears.
- All-zero guard: the `hist != 0` condition prevents lock on an all-zero stream. The LFSR loaded at lock is nonzero, so it never sticks.
- Counters saturate at all-ones; they never wrap.
- `i_clear` has priority over increments in the same cycle. A bit arriving with `i_clear` still advances the FSM, LFSR and window logic but is not counted.

## Timing
- Reset values: `o_lock`=0, `o_errors`=0, `o_bits`=0, `o_sync_loss`=0, state FILL, `hist`=0, `good`=0, `win_cnt`=0, `win_err`=0.
- All outputs are registered. A valid bit at edge k is reflected in the counters after edge k.
- Acquisition latency from reset with a clean stream is 9 + `LOCK_CNT` valid bits. `o_lock` rises after the edge that samples the last of these bits. The next valid bit is the first one counted.
- `o_lock` falls after the edge that samples the window-closing bit that trips the threshold. That bit is still counted.
- `i_reset` mid-operation (any state) returns everything to reset values on the next edge, regardless of `i_valid` or `i_clear`.
- `i_valid` gaps of any length are transparent: behaviour depends only on the sequence of valid bits.

## Structure
- Package `prbs_pkg`: PRBS9 tap constants (`PRBS9_LEN`=9, `PRBS9_TAP`=5) and a state enum (FILL, ACQUIRE, LOCKED). The package is shared with `prbs9`.
- One natural sub-module: `sat_counter` (parameterized width, synchronous clear, increment enable, saturation). It is instantiated three times: `o_errors`, `o_bits`, `o_sync_loss`.

## Test plan
- Clean lock: `prbs9` (seed 0x1AA) → 11-cycle delay → `i_rx`, `i_valid`=1. `o_lock` rises after valid bit 25. After 10000 further bits: `o_bits`=10000, `o_errors`=0.
- Single error: while locked, invert one bit. `o_errors`=1 exactly, `o_lock` stays 1, `o_sync_loss`=0.
- Burst: invert 20 consecutive bits inside one window. `o_sync_loss`=1 and `o_lock` falls at that window's end. Relock occurs within `LOCK_CNT` clean bits, and `o_errors` is unchanged after relock.
- All-zero input for 1000 valid bits: `o_lock` stays 0, all counters 0.
- Gapped valid: `i_valid` toggling 1-0-0 with a PRBS stream. Lock after 25 valid bits; `o_bits` equals the count of valid bits after lock.
- Clear and reset: assert `i_clear` together with an erroneous valid bit while locked → counters 0 next cycle and that error is not counted. Then assert `i_reset` while locked → all outputs 0 and state FILL.
